// File: rtl/rf_sequencer_pkg.sv
// Shared definitions for the RISC control sequencer: opcodes, ALU and W-mux
// encodings, FSM states and small decode helpers.
package rf_sequencer_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;

   localparam logic [3:0] OP_NOP    = 4'd0;
   localparam logic [3:0] OP_ADD    = 4'd1;
   localparam logic [3:0] OP_SUB    = 4'd2;
   localparam logic [3:0] OP_AND    = 4'd3;
   localparam logic [3:0] OP_OR     = 4'd4;
   localparam logic [3:0] OP_MOV    = 4'd5;
   localparam logic [3:0] OP_LDI    = 4'd6;
   localparam logic [3:0] OP_SWAP   = 4'd7;
   localparam logic [3:0] OP_CLRALL = 4'd8;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_AND    = 4'd2;
   localparam logic [3:0] ALU_OR     = 4'd3;
   localparam logic [3:0] ALU_PASS_R = 4'd4;

   localparam logic [1:0] WSEL_ALU  = 2'd0;
   localparam logic [1:0] WSEL_IMM  = 2'd1;
   localparam logic [1:0] WSEL_ZERO = 2'd2;
   localparam logic [1:0] WSEL_TMP  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_WRITE  = 3'd2,
      ST_SWAP2  = 3'd3,
      ST_CLR    = 3'd4
   } state_e;

   function automatic logic op_illegal(input logic [3:0] op);
      return op > OP_CLRALL;
   endfunction

   // MOV and SWAP both route the R operand straight through the ALU.
   function automatic logic [3:0] op_to_alu(input logic [3:0] op);
      case (op)
         OP_ADD:  return ALU_ADD;
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         default: return ALU_PASS_R;
      endcase
   endfunction

endpackage

// File: rtl/rf_sequencer_if.sv
// Instruction handshake plus register-file / ALU / W-mux control bundle.
interface rf_sequencer_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic [DATA_W-1:0] instr;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] s_bus;
   logic [ADDR_W-1:0] w_addr;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] s_addr;
   logic              we;
   logic [3:0]        alu_op;
   logic [1:0]        w_sel;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] tmp;
   logic              busy;
   logic              done;
   logic              illegal;

   modport slave (
      input  instr, instr_valid, s_bus,
      output instr_ready, w_addr, r_addr, s_addr, we, alu_op, w_sel,
             imm, tmp, busy, done, illegal
   );

   modport master (
      output instr, instr_valid, s_bus,
      input  instr_ready, w_addr, r_addr, s_addr, we, alu_op, w_sel,
             imm, tmp, busy, done, illegal
   );
endinterface

// File: rtl/rf_sequencer.sv
// Multi-cycle sequencer for the 16-bit RISC datapath: decodes one instruction
// per handshake and drives register-file, ALU and W-mux controls per cycle.
module rf_sequencer
   import rf_sequencer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic          clk,
   input  logic          reset,
   rf_sequencer_if.slave bus
);

   localparam int                NREGS = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NREGS - 1);

   state_e            r_state;
   logic [DATA_W-1:0] r_ir;
   logic [DATA_W-1:0] r_tmp;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] r_w_addr;
   logic [ADDR_W-1:0] r_r_addr;
   logic [ADDR_W-1:0] r_s_addr;
   logic              r_we;
   logic              r_done;
   logic              r_illegal;
   logic              r_ready;
   logic              r_busy;
   logic [3:0]        r_alu_op;
   logic [1:0]        r_w_sel;

   logic [3:0]        w_op;
   logic [3:0]        w_in_op;
   logic [ADDR_W-1:0] w_rd;
   logic [ADDR_W-1:0] w_rs;
   logic [ADDR_W-1:0] w_rt;
   logic [ADDR_W-1:0] w_cnt_nxt;
   logic              w_accept;

   assign w_op      = r_ir[15:12];
   assign w_rd      = r_ir[9 +: ADDR_W];
   assign w_rs      = r_ir[6 +: ADDR_W];
   assign w_rt      = r_ir[3 +: ADDR_W];
   assign w_in_op   = bus.instr[15:12];
   assign w_cnt_nxt = r_cnt + 1'b1;
   assign w_accept  = bus.instr_valid & r_ready;

   // Outputs are registered: each transition loads the controls of the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_ir      <= '0;
         r_tmp     <= '0;
         r_cnt     <= '0;
         r_w_addr  <= '0;
         r_r_addr  <= '0;
         r_s_addr  <= '0;
         r_we      <= 1'b0;
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_alu_op  <= ALU_ADD;
         r_w_sel   <= WSEL_ALU;
      end else begin
         r_we      <= 1'b0;
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
         r_w_addr  <= '0;
         r_r_addr  <= '0;
         r_s_addr  <= '0;
         r_alu_op  <= ALU_ADD;
         r_w_sel   <= WSEL_ALU;

         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_ir      <= bus.instr;
                  r_state   <= ST_DECODE;
                  r_ready   <= 1'b0;
                  r_busy    <= 1'b1;
                  r_done    <= (w_in_op == OP_NOP) || op_illegal(w_in_op);
                  r_illegal <= op_illegal(w_in_op);
               end
            end

            ST_DECODE: begin
               if (w_op == OP_NOP || op_illegal(w_op)) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end else if (w_op == OP_CLRALL) begin
                  r_state  <= ST_CLR;
                  r_cnt    <= '0;
                  r_we     <= 1'b1;
                  r_w_sel  <= WSEL_ZERO;
               end else begin
                  r_state  <= ST_WRITE;
                  r_we     <= 1'b1;
                  r_w_addr <= w_rd;
                  r_r_addr <= w_rs;
                  r_s_addr <= (w_op == OP_SWAP) ? w_rd : w_rt;
                  r_alu_op <= op_to_alu(w_op);
                  r_w_sel  <= (w_op == OP_LDI) ? WSEL_IMM : WSEL_ALU;
                  r_done   <= (w_op != OP_SWAP);
               end
            end

            ST_WRITE: begin
               if (w_op == OP_SWAP) begin
                  // s_bus still carries the old rd: the first write lands on this same edge.
                  r_tmp    <= bus.s_bus;
                  r_state  <= ST_SWAP2;
                  r_we     <= 1'b1;
                  r_w_addr <= w_rs;
                  r_w_sel  <= WSEL_TMP;
                  r_done   <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end

            ST_SWAP2: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end

            ST_CLR: begin
               if (r_cnt == LAST) begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt    <= w_cnt_nxt;
                  r_we     <= 1'b1;
                  r_w_addr <= w_cnt_nxt;
                  r_w_sel  <= WSEL_ZERO;
                  r_done   <= (w_cnt_nxt == LAST);
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.instr_ready = r_ready;
   assign bus.busy        = r_busy;
   assign bus.we          = r_we;
   assign bus.done        = r_done;
   assign bus.illegal     = r_illegal;
   assign bus.w_addr      = r_w_addr;
   assign bus.r_addr      = r_r_addr;
   assign bus.s_addr      = r_s_addr;
   assign bus.alu_op      = r_alu_op;
   assign bus.w_sel       = r_w_sel;
   assign bus.tmp         = r_tmp;
   assign bus.imm         = {{(DATA_W - 8){1'b0}}, r_ir[7:0]};

endmodule

// File: tb/tb_rf_sequencer.sv
// Scoreboard bench for rf_sequencer with a behavioural 8x16 register file,
// ALU and W mux closing the loop around the sequencer.
module tb_rf_sequencer;

   logic clk;
   logic reset;

   rf_sequencer_if #(.DATA_W(16), .ADDR_W(3)) sif ();

   rf_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  addr;
      logic [15:0] data;
      logic [1:0]  wsel;
      logic        done;
      logic        ill;
      int          lat;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   logic mon_en   = 1'b0;

   // datapath environment
   logic [15:0] rf [8];
   logic [15:0] ra, sa, alu_res, wdata;
   logic        pl_en = 1'b0;
   logic [2:0]  pl_a  = '0;
   logic [15:0] pl_d  = '0;

   assign sif.s_bus = rf[sif.s_addr];

   always_comb begin
      ra = rf[sif.r_addr];
      sa = rf[sif.s_addr];
      alu_res = '0;
      case (sif.alu_op)
         4'd0: alu_res = ra + sa;
         4'd1: alu_res = ra - sa;
         4'd2: alu_res = ra & sa;
         4'd3: alu_res = ra | sa;
         4'd4: alu_res = ra;
         default: alu_res = '0;
      endcase
      case (sif.w_sel)
         2'd0: wdata = alu_res;
         2'd1: wdata = sif.imm;
         2'd2: wdata = '0;
         default: wdata = sif.tmp;
      endcase
   end

   always @(posedge clk) begin
      if (pl_en) rf[pl_a] <= pl_d;
      else if (sif.we) rf[sif.w_addr] <= wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_w(input logic [2:0] a, input logic [15:0] d, input logic [1:0] ws,
                         input logic dn, input int lat);
      exp_t e;
      e.we = 1'b1; e.addr = a; e.data = d; e.wsel = ws; e.done = dn; e.ill = 1'b0; e.lat = lat;
      q.push_back(e);
   endtask

   task automatic push_d(input logic il, input int lat);
      exp_t e;
      e.we = 1'b0; e.addr = '0; e.data = '0; e.wsel = '0; e.done = 1'b1; e.ill = il; e.lat = lat;
      q.push_back(e);
   endtask

   // monitor: pops one expectation per cycle showing we/done/illegal
   initial begin
      int cyc = 0;
      int acc_cyc = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (mon_en && (sif.we || sif.done || sif.illegal)) begin
            if (q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_output: we=%0b done=%0b illegal=%0b w_addr=%0d, none expected",
                        sif.we, sif.done, sif.illegal, sif.w_addr);
            end else begin
               e = q.pop_front();
               chk("we", 32'(sif.we), 32'(e.we));
               chk("done", 32'(sif.done), 32'(e.done));
               chk("illegal", 32'(sif.illegal), 32'(e.ill));
               chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
               if (e.we) begin
                  chk("w_addr", 32'(sif.w_addr), 32'(e.addr));
                  chk("w_sel", 32'(sif.w_sel), 32'(e.wsel));
                  chk("w_data", 32'(wdata), 32'(e.data));
               end
            end
         end
         if (sif.instr_valid && sif.instr_ready) acc_cyc = cyc;
      end
   end

   task automatic preload(input logic [2:0] a, input logic [15:0] d);
      pl_en = 1'b1; pl_a = a; pl_d = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic send(input logic [15:0] w);
      bit ok = 1'b0;
      sif.instr = w;
      sif.instr_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sif.instr_ready) begin ok = 1'b1; break; end
      end
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL accept_timeout: instr %0h not accepted within 100 cycles", w);
      end
      @(posedge clk); #1;
      sif.instr_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (q.size() == 0) break;
         @(negedge clk);
      end
      chk("queue_drained", 32'(q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      reset = 1'b1;
      sif.instr = '0;
      sif.instr_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(sif.instr_ready), 32'd1);
      chk("rst_busy", 32'(sif.busy), 32'd0);
      chk("rst_we", 32'(sif.we), 32'd0);
      chk("rst_done", 32'(sif.done), 32'd0);
      chk("rst_illegal", 32'(sif.illegal), 32'd0);
      chk("rst_addrs", {23'd0, sif.w_addr, sif.r_addr, sif.s_addr}, 32'd0);
      chk("rst_tmp", 32'(sif.tmp), 32'd0);
      reset = 1'b0;
      mon_en = 1'b1;

      // LDI r2,0xA5
      push_w(3'd2, 16'h00A5, 2'd1, 1'b1, 2);
      send(16'h64A5);
      drain();
      chk("ldi_r2", 32'(rf[2]), 32'h00A5);

      // ADD r4,r1,r3 with r1=5, r3=7
      preload(3'd1, 16'd5);
      preload(3'd3, 16'd7);
      push_w(3'd4, 16'd12, 2'd0, 1'b1, 2);
      send(16'h1858);
      drain();
      chk("add_r4", 32'(rf[4]), 32'd12);

      // NOP
      push_d(1'b0, 1);
      send(16'h0000);
      drain();

      // SWAP r1,r2
      preload(3'd1, 16'h1111);
      preload(3'd2, 16'h2222);
      push_w(3'd1, 16'h2222, 2'd0, 1'b0, 2);
      push_w(3'd2, 16'h1111, 2'd3, 1'b1, 3);
      send(16'h7280);
      drain();
      chk("swap_r1", 32'(rf[1]), 32'h2222);
      chk("swap_r2", 32'(rf[2]), 32'h1111);
      chk("swap_tmp", 32'(sif.tmp), 32'h1111);

      // SWAP back while an illegal opcode is held on the bus
      push_w(3'd1, 16'h1111, 2'd0, 1'b0, 2);
      push_w(3'd2, 16'h2222, 2'd3, 1'b1, 3);
      push_d(1'b1, 1);
      send(16'h7280);
      sif.instr = 16'hF000;
      sif.instr_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("hold_ready", 32'(sif.instr_ready), 32'd0);
         chk("hold_busy", 32'(sif.busy), 32'd1);
      end
      send(16'hF000);
      drain();
      chk("swapback_r1", 32'(rf[1]), 32'h1111);

      // CLRALL with every register loaded
      for (int i = 0; i < 8; i++) preload(3'(i), 16'(16'h1000 + i + 1));
      for (int i = 0; i < 8; i++) push_w(3'(i), 16'h0000, 2'd2, (i == 7), 2 + i);
      send(16'h8000);
      drain();
      for (int i = 0; i < 8; i++) chk("clr_reg", 32'(rf[i]), 32'd0);

      // reset during CLRALL at cnt=3
      for (int i = 0; i < 4; i++) push_w(3'(i), 16'h0000, 2'd2, 1'b0, 2 + i);
      send(16'h8000);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (sif.we && sif.w_addr == 3'd3) begin seen = 1'b1; break; end
      end
      chk("clr_reached_cnt3", 32'(seen), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_we", 32'(sif.we), 32'd0);
      chk("abort_ready", 32'(sif.instr_ready), 32'd1);
      chk("abort_busy", 32'(sif.busy), 32'd0);
      chk("abort_done", 32'(sif.done), 32'd0);
      chk("abort_w_addr", 32'(sif.w_addr), 32'd0);
      repeat (3) @(negedge clk);
      chk("abort_queue", 32'(q.size()), 32'd0);
      @(posedge clk); #1;

      // recovery after abort: LDI r5,0x3C
      push_w(3'd5, 16'h003C, 2'd1, 1'b1, 2);
      send(16'h6A3C);
      drain();
      chk("ldi_r5", 32'(rf[5]), 32'h003C);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
